uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encodings, the bus
// region base and the parity helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Value of bus address bits [31:27] that selects the UART region.
    localparam logic [4:0] UART_REGION_BASE = 5'b1010_0;

    localparam int UART_DATA_W = 8;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO, DEPTH x 8, head word visible combinationally on o_dout.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [UART_DATA_W-1:0]   i_din,
    input  logic                     i_pop,
    output logic [UART_DATA_W-1:0]   o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   w_push_ok;
    logic                   w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Bus-written UART transmitter with FIFO, 8N1 framing; define UART_PARITY_EN
// to insert an even-parity bit between the data bits and the stop bit.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         uart_cen,
    input  logic                         uart_wr,
    input  logic [UART_DATA_W-1:0]       uart_wdata,
    output logic                         uart_error,
    output logic                         txd,
    output logic                         tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

    uart_state_e            r_state;
    uart_state_e            w_state_nxt;
    logic [15:0]            r_baud;
    logic [15:0]            w_baud_nxt;
    logic [2:0]             r_idx;
    logic [2:0]             w_idx_nxt;
    logic [2:0]             w_idx_inc;
    logic [UART_DATA_W-1:0] r_shift;
    logic                   r_txd;
    logic                   w_txd_nxt;
    logic                   w_baud_done;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic [UART_DATA_W-1:0] w_fifo_dout;

    // Full comes from the registered count, so a same-cycle pop never makes room.
    assign uart_error = uart_cen & (~uart_wr | w_full);
    assign w_push     = uart_cen & uart_wr & ~w_full & ~rst;
    assign txd        = r_txd;
    assign tx_busy    = (r_state != ST_IDLE) | ~w_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (uart_wdata),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign w_baud_done = (r_baud == 16'd0);
    assign w_idx_inc   = r_idx + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_baud_done ? r_baud : r_baud - 16'd1;
        w_idx_nxt   = r_idx;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_txd_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                    w_baud_nxt  = BAUD_RELOAD;
                    w_txd_nxt   = 1'b0;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_state_nxt = ST_DATA;
                    w_baud_nxt  = BAUD_RELOAD;
                    w_idx_nxt   = 3'd0;
                    w_txd_nxt   = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = BAUD_RELOAD;
                    if (r_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_txd_nxt   = even_parity(r_shift);
`else
                        w_state_nxt = ST_STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_txd_nxt = r_shift[w_idx_inc];
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (w_baud_done) begin
                    w_state_nxt = ST_STOP;
                    w_baud_nxt  = BAUD_RELOAD;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (w_baud_done) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_START;
                        w_baud_nxt  = BAUD_RELOAD;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_baud_nxt  = 16'd0;
                        w_txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_baud_nxt  = 16'd0;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_baud  <= 16'd0;
            r_idx   <= 3'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_idx   <= w_idx_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift <= w_fifo_dout;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=8 (parity expectations follow UART_PARITY_EN).
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       uart_cen   = 1'b0;
    logic       uart_wr    = 1'b0;
    logic [7:0] uart_wdata = 8'h00;
    logic       uart_error;
    logic       txd;
    logic       tx_busy;
    logic [3:0] fifo_count;

    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         cyc     = 0;
    int         t0      = 0;
    int         n_bytes = 0;
    logic [7:0] exp_bytes [16];

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_cen   (uart_cen),
        .uart_wr    (uart_wr),
        .uart_wdata (uart_wdata),
        .uart_error (uart_error),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level k edges after the first byte of the current burst was pushed.
    function automatic logic exp_line(input int k);
        int         f;
        int         b;
        logic [7:0] d;
        if (k < 1) return 1'b1;
        f = (k - 1) / FRAME;
        b = ((k - 1) % FRAME) / CPB;
        if (f >= n_bytes) return 1'b1;
        d = exp_bytes[f];
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_chk();
        int k;
        tick();
        k = cyc - t0;
        chk_eq($sformatf("txd k=%0d", k), 32'(txd), 32'(exp_line(k)));
        chk_eq($sformatf("busy k=%0d", k), 32'(tx_busy), 32'(k <= n_bytes * FRAME));
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic exp_err, input string tag);
        uart_cen   = 1'b1;
        uart_wr    = 1'b1;
        uart_wdata = d;
        #1;
        chk_eq(tag, 32'(uart_error), 32'(exp_err));
    endtask

    task automatic single_frame(input logic [7:0] d);
        exp_bytes[0] = d;
        n_bytes      = 1;
        t0           = cyc + 1;
        wr_byte(d, 1'b0, "wr_err_single");
        tick_chk();
        uart_cen = 1'b0;
        uart_wr  = 1'b0;
        chk_eq("count_after_push", 32'(fifo_count), 32'd1);
        tick_chk();
        chk_eq("count_after_pop", 32'(fifo_count), 32'd0);
        repeat (FRAME + 3) tick_chk();
    endtask

    initial begin
        // Reset state and bus behaviour while reset is held
        tick();
        tick();
        chk_eq("rst_txd", 32'(txd), 32'd1);
        chk_eq("rst_busy", 32'(tx_busy), 32'd0);
        chk_eq("rst_count", 32'(fifo_count), 32'd0);
        chk_eq("rst_err_idle", 32'(uart_error), 32'd0);
        uart_cen = 1'b1;
        uart_wr  = 1'b0;
        #1;
        chk_eq("rst_read_err", 32'(uart_error), 32'd1);
        uart_wr    = 1'b1;
        uart_wdata = 8'hFF;
        #1;
        chk_eq("rst_write_err", 32'(uart_error), 32'd0);
        tick();
        chk_eq("rst_write_ignored", 32'(fifo_count), 32'd0);
        chk_eq("rst_write_busy", 32'(tx_busy), 32'd0);
        uart_cen = 1'b0;
        uart_wr  = 1'b0;
        rst      = 1'b0;
        tick();
        chk_eq("post_rst_txd", 32'(txd), 32'd1);

        // Read access while idle
        uart_cen = 1'b1;
        uart_wr  = 1'b0;
        #1;
        chk_eq("read_err", 32'(uart_error), 32'd1);
        tick();
        uart_cen = 1'b0;
        chk_eq("read_txd", 32'(txd), 32'd1);
        chk_eq("read_count", 32'(fifo_count), 32'd0);
        chk_eq("read_busy", 32'(tx_busy), 32'd0);

        // Deselected write
        uart_wr    = 1'b1;
        uart_wdata = 8'h12;
        #1;
        chk_eq("nocen_err", 32'(uart_error), 32'd0);
        tick();
        uart_wr = 1'b0;
        chk_eq("nocen_count", 32'(fifo_count), 32'd0);

        // Single frames
        single_frame(8'h55);
        single_frame(8'h07);

        // Nine back-to-back writes, then nine rejected writes and a read
        exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h80; exp_bytes[2] = 8'hC3;
        exp_bytes[3] = 8'h3C; exp_bytes[4] = 8'hFF; exp_bytes[5] = 8'h00;
        exp_bytes[6] = 8'hA5; exp_bytes[7] = 8'h5A; exp_bytes[8] = 8'h96;
        n_bytes = 9;
        t0      = cyc + 1;
        for (int i = 0; i < 9; i++) begin
            wr_byte(exp_bytes[i], 1'b0, $sformatf("burst_err%0d", i));
            tick_chk();
        end
        uart_cen = 1'b0;
        chk_eq("burst_count", 32'(fifo_count), 32'd8);
        for (int i = 0; i < 9; i++) begin
            wr_byte(8'hEE, 1'b1, $sformatf("full_err%0d", i));
            tick_chk();
            chk_eq($sformatf("full_count%0d", i), 32'(fifo_count), 32'd8);
        end
        uart_wr = 1'b0;
        #1;
        chk_eq("full_read_err", 32'(uart_error), 32'd1);
        tick_chk();
        uart_cen = 1'b0;
        chk_eq("full_read_count", 32'(fifo_count), 32'd8);
        while ((cyc - t0) < 9 * FRAME + 4) tick_chk();
        chk_eq("burst_drained", 32'(fifo_count), 32'd0);

        // Reset in the middle of the data bits of 0xA3 with three bytes queued
        wr_byte(8'hA3, 1'b0, "abort_wr0"); tick();
        wr_byte(8'h11, 1'b0, "abort_wr1"); tick();
        wr_byte(8'h22, 1'b0, "abort_wr2"); tick();
        wr_byte(8'h33, 1'b0, "abort_wr3"); tick();
        uart_cen = 1'b0;
        uart_wr  = 1'b0;
        chk_eq("abort_count", 32'(fifo_count), 32'd3);
        repeat (11) tick();
        chk_eq("abort_mid_bit2", 32'(txd), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("abort_txd", 32'(txd), 32'd1);
        chk_eq("abort_count0", 32'(fifo_count), 32'd0);
        chk_eq("abort_busy", 32'(tx_busy), 32'd0);
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            chk_eq($sformatf("abort_quiet%0d", i), 32'(txd), 32'd1);
        end
        chk_eq("abort_busy_end", 32'(tx_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
